// File: rtl/serial_parity_rx.sv
// Serial frame receiver: deserialises DATA_W data bits (LSB first) followed
// by one parity bit, checks the parity with a running XOR, and offers the
// recovered word plus a parity-error flag through a valid/ready handshake.
module serial_parity_rx #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sof,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              busy,
  output logic              overrun
);

  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dvalid_q, dvalid_d;
  logic              perr_q, perr_d;
  logic              overrun_d;
  logic              start;
  logic              xfer;

  // Bits enter at the MSB and move right, so after DATA_W shifts the first
  // received bit sits at bit 0 (LSB-first ordering).
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sreg,
                                                 input logic              b);
    shift_in = {b, sreg[DATA_W-1:1]};
  endfunction

  // Handshake: a result leaves only while it is actually being offered.
  assign xfer = dvalid_q & out_ready;

  // Next-state, datapath updates and the overrun pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    par_d     = par_q;
    dout_d    = dout_q;
    dvalid_d  = dvalid_q;
    perr_d    = perr_q;
    overrun_d = 1'b0;
    start     = 1'b0;

    case (state_q)
      IDLE: begin
        // Bits without a preceding sof are simply not part of any frame.
        if (sof) start = 1'b1;
      end

      DATA: begin
        if (sof) begin
          start = 1'b1;
        end else if (bit_valid) begin
          sreg_d = shift_in(sreg_q, bit_in);
          par_d  = par_q ^ bit_in;
          // Counter parks on the last index instead of wrapping.
          if (cnt_q == CNT_LAST) state_d = PAR;
          else                   cnt_d   = cnt_q + CNT_ONE;
        end
      end

      PAR: begin
        if (sof) begin
          start = 1'b1;
        end else if (bit_valid) begin
          dout_d   = sreg_q;
          perr_d   = (bit_in != (par_q ^ PARITY_ODD));
          dvalid_d = 1'b1;
          state_d  = HOLD;
        end
      end

      HOLD: begin
        if (xfer) begin
          dvalid_d = 1'b0;
          state_d  = IDLE;
          // A new frame may begin in the very cycle the old result leaves.
          if (sof) start = 1'b1;
        end else if (sof || bit_valid) begin
          // Result still held: incoming input has nowhere to go.
          overrun_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Common frame (re)start; a bit valid in the same cycle is data bit 0.
    if (start) begin
      state_d = DATA;
      cnt_d   = '0;
      par_d   = 1'b0;
      sreg_d  = '0;
      if (bit_valid) begin
        sreg_d = shift_in('0, bit_in);
        par_d  = bit_in;
        cnt_d  = CNT_ONE;
      end
    end
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sreg_q   <= '0;
      par_q    <= 1'b0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sreg_q   <= sreg_d;
      par_q    <= par_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      perr_q   <= perr_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dvalid_q;
  assign parity_err = perr_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_d;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx: an even-parity and an odd-parity
// instance share the same input stream.
module tb_serial_parity_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sof, bit_in, bit_valid, out_ready;
  logic [7:0] data_out, data_out_o;
  logic       data_valid, data_valid_o;
  logic       parity_err, parity_err_o;
  logic       busy, busy_o;
  logic       overrun, overrun_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .sof(sof), .bit_in(bit_in),
    .bit_valid(bit_valid), .out_ready(out_ready),
    .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
    .busy(busy), .overrun(overrun)
  );

  serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .sof(sof), .bit_in(bit_in),
    .bit_valid(bit_valid), .out_ready(out_ready),
    .data_out(data_out_o), .data_valid(data_valid_o), .parity_err(parity_err_o),
    .busy(busy_o), .overrun(overrun_o)
  );

  // One input cycle: inputs change on the falling edge, DUT samples on the rising edge.
  task automatic cyc(input logic s, input logic bv, input logic b, input logic rdy);
    @(negedge clk);
    sof = s; bit_valid = bv; bit_in = b; out_ready = rdy;
  endtask

  // sof, 8 data bits LSB first (optional random gaps), parity bit, one idle cycle.
  // Returns #1 after the falling edge at which data_valid is expected high.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic rdy,
                            input int max_gap);
    cyc(1'b1, 1'b0, 1'b0, rdy);
    for (int i = 0; i < 8; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int k = 0; k < g; k++) cyc(1'b0, 1'b0, 1'b0, rdy);
      cyc(1'b0, 1'b1, d[i], rdy);
    end
    cyc(1'b0, 1'b1, p, rdy);
    cyc(1'b0, 1'b0, 1'b0, rdy);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sof = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
    #12;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid: got %b want 0", data_valid); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_idle_ignore;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy[%0d]: got %b want 0", i, busy); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL idle_overrun[%0d]: got %b want 0", i, overrun); end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL idle_data_valid: got %b want 0", data_valid); end
  endtask

  task automatic test_basic;
    // 0xA5 has four ones: even parity bit is 0
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", data_valid); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", data_out); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL basic_perr: got %b want 0", parity_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_hold: got %b want 1", busy); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_one_cycle: got %b want 0", data_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle: got %b want 0", busy); end

    send_frame(8'hA5, 1'b1, 1'b1, 0);
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL badpar_data: got %h want a5", data_out); end
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL badpar_perr: got %b want 1", parity_err); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_odd_parity;
    // 0x01 has one '1': odd expects parity 0, even expects parity 1
    send_frame(8'h01, 1'b0, 1'b1, 0);
    checks++; if (data_out_o !== 8'h01) begin errors++; $display("FAIL odd_p0_data: got %h want 01", data_out_o); end
    checks++; if (parity_err_o !== 1'b0) begin errors++; $display("FAIL odd_p0_perr: got %b want 0", parity_err_o); end
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL even_p0_perr: got %b want 1", parity_err); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h01, 1'b1, 1'b1, 0);
    checks++; if (parity_err_o !== 1'b1) begin errors++; $display("FAIL odd_p1_perr: got %b want 1", parity_err_o); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL even_p1_perr: got %b want 0", parity_err); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure;
    int pulses;
    pulses = 0;
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, (k == 1 || k == 3), 1'b1, 1'b0); #1;
      checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", k, data_valid); end
      checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL bp_data[%0d]: got %h want 3c", k, data_out); end
      checks++; if (overrun !== (k == 1 || k == 3)) begin errors++; $display("FAIL bp_overrun[%0d]: got %b want %b", k, overrun, (k == 1 || k == 3)); end
      if (overrun === 1'b1) pulses++;
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL bp_pulse_count: got %0d want 2", pulses); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL bp_perr: got %b want 0", parity_err); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_before_xfer: got %b want 1", data_valid); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after_xfer: got %b want 0", data_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b want 0", busy); end
  endtask

  task automatic test_resync;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1, 0);
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL resync_valid: got %b want 1", data_valid); end
    checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL resync_data: got %h want ff", data_out); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL resync_perr: got %b want 0", parity_err); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midframe;
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", data_valid); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, (i < 5), 1'b1, 1'b1); #1;
      checks++; if (data_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_after[%0d]: got valid=%b busy=%b want 0 0", i, data_valid, busy); end
    end
  endtask

  task automatic test_gaps;
    send_frame(8'h5A, 1'b0, 1'b1, 3);
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL gaps_data: got %h want 5a", data_out); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL gaps_perr: got %b want 0", parity_err); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic [7:0] nxt;
    nxt = 8'h0F;
    send_frame(8'h96, 1'b0, 1'b0, 0);
    checks++; if (data_out !== 8'h96) begin errors++; $display("FAIL b2b_first_data: got %h want 96", data_out); end
    // transfer and sof together, bit 0 of the next frame in the same cycle
    cyc(1'b1, 1'b1, nxt[0], 1'b1); #1;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    for (int i = 1; i < 8; i++) begin
      cyc(1'b0, 1'b1, nxt[i], 1'b1);
      if (i == 1) begin
        #1;
        checks++; if (data_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got valid=%b busy=%b want 0 1", data_valid, busy); end
      end
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b1);  // wrong parity for 0x0F under even parity
    cyc(1'b0, 1'b0, 1'b0, 1'b1); #1;
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", data_valid); end
    checks++; if (data_out !== 8'h0F) begin errors++; $display("FAIL b2b_data: got %h want 0f", data_out); end
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL b2b_perr: got %b want 1", parity_err); end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic();
    test_odd_parity();
    test_backpressure();
    test_resync();
    test_reset_midframe();
    test_gaps();
    test_back_to_back();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
- Receives a serial bit stream, deserialises one frame of DATA_W data bits plus one parity bit, and checks parity.
- Parity is accumulated as a running XOR, one XOR per accepted data bit.
- Sits directly downstream of the team's XOR gate primitives and is the first sequential consumer of a running XOR.
- Presents the recovered word and a parity-error flag to the next stage through a valid/ready handshake.

Parameters:
- DATA_W, 8, number of data bits per frame (2..32).
- PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sof  input  1  start-of-frame strobe; the next accepted bits begin a new frame.
- bit_in  input  1  serial data, LSB first, then the parity bit.
- bit_valid  input  1  bit_in is sampled on this edge.
- out_ready  input  1  downstream can accept the result.
- data_out  output  DATA_W  recovered data word.
- data_valid  output  1  data_out and parity_err are valid.
- parity_err  output  1  received parity bit did not match the expected parity.
- busy  output  1  a frame is in progress or a result is being held.
- overrun  output  1  one-cycle pulse when an input bit or sof is dropped in HOLD.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state = IDLE; bit counter, shift register and running parity cleared.
  - data_out = 0, data_valid = 0, parity_err = 0, busy = 0, overrun = 0.
  - Reset mid-frame discards the partial frame; no result is emitted.
- States: IDLE, DATA, PAR, HOLD.
- IDLE:
  - sof = 1 -> DATA; counter = 0, running parity = 0.
  - If bit_valid is also high in that cycle, that bit is data bit 0.
  - bit_valid without a prior sof is ignored; no overrun.
- DATA:
  - Each bit_valid shifts bit_in into position counter (LSB first).
  - running parity <= running parity XOR bit_in; counter increments.
  - After the bit taken with counter = DATA_W-1 -> PAR.
  - Cycles with bit_valid = 0 are gaps: no state change.
- PAR:
  - On bit_valid, expected = running parity XOR PARITY_ODD.
  - parity_err <= (bit_in != expected); data_out <= shift register; data_valid <= 1 -> HOLD.
  - data_valid rises the cycle after the parity bit is sampled.
- sof in DATA or PAR: aborts the frame, restarts DATA with counter = 0 and running parity = 0. The same-cycle bit rule is as in IDLE.
- HOLD:
  - data_out, parity_err and data_valid are stable until data_valid & out_ready.
  - On transfer, data_valid clears next cycle; state -> IDLE.
  - If sof is high in the transfer cycle, state goes directly to DATA (same-cycle bit rule applies).
  - bit_valid or sof without a transfer: input is dropped and overrun pulses high for that cycle.
- busy = 1 in DATA, PAR and HOLD; 0 in IDLE.
- out_ready is ignored when data_valid = 0.
- Counter width is clog2(DATA_W); it never wraps past DATA_W-1 within a frame.

Test Plan:
- DATA_W = 8, PARITY_ODD = 0: sof, bits of 0xA5 LSB first, parity 0, out_ready = 1 -> data_out = 0xA5, parity_err = 0, data_valid for exactly 1 cycle.
- Same frame with parity bit 1 -> data_out = 0xA5, parity_err = 1.
- PARITY_ODD = 1: frame 0x01 with parity 0 -> parity_err = 0; frame 0x01 with parity 1 -> parity_err = 1.
- Backpressure and overrun:
  - Frame 0x3C with out_ready = 0 for 5 cycles -> data_valid and data_out held stable throughout.
  - Two bit_valid pulses in that window -> two single-cycle overrun pulses.
  - Raise out_ready -> transfer, then IDLE.
- Resync and reset:
  - sof, 3 bits, second sof, then 0xFF with parity 0 -> data_out = 0xFF, parity_err = 0; the first 3 bits have no effect.
  - Assert rst_n = 0 after 4 bits of a frame -> all outputs 0 immediately; no data_valid afterwards.
- Gaps and simultaneous events:
  - Random 0..3-cycle bit_valid gaps inside a frame of 0x5A -> same result as gap-free.
  - sof together with the HOLD transfer -> next frame decodes correctly.
